wra_dma_reader: RTL and testbench
=================================

WRA_DMA_READER -- requirements
Module: wra_dma_reader

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent read channels (ch0 = feature, ch1 = filter).
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter CNT_W, default 16, transfer-size width.
REQ-004 Parameter DATA_W, default 512, memory read-data width.
REQ-005 Ports are listed in REQ-006..REQ-019; one clock, reset asynchronous and active-high.
REQ-006 HCLK  input  1  clock; all state updates on its rising edge.
REQ-007 HRESET  input  1  asynchronous active-high reset.
REQ-008 ch_start  input  NUM_CH  per-channel one-cycle start pulse.
REQ-009 ch_addr  input  NUM_CH*ADDR_W  per-channel start address, sampled at start.
REQ-010 ch_size  input  NUM_CH*CNT_W  per-channel last beat offset; beats = size+1, sampled at start.
REQ-011 dst_ready  input  1  consumer can accept a beat issued this cycle.
REQ-012 mem_addr  output  ADDR_W  synchronous-memory read address.
REQ-013 mem_rd  output  1  read strobe; memory data returns one cycle later.
REQ-014 mem_rdata  input  DATA_W  memory read data.
REQ-015 out_valid, out_data (DATA_W), out_ch ($clog2(NUM_CH)), out_offset (CNT_W)  outputs  beat valid, data, channel, offset from start address.
REQ-016 ch_busy  output  NUM_CH  channel pending or active.
REQ-017 ch_done  output  NUM_CH  one-cycle pulse per channel on completion.
REQ-018 start_err  output  1  sticky; start received on a busy channel.
REQ-019 ch_abort  input  NUM_CH  per-channel abort (present only with WRA_DMA_ABORT_EN).

Function
REQ-020 Channel states: IDLE -> PENDING on ch_start; PENDING -> ACTIVE when granted; ACTIVE -> IDLE after final beat.
REQ-021 Engine FSM: IDLE, ISSUE, DRAIN; one channel ACTIVE at a time, non-preemptive.
REQ-022 Grant in IDLE: round-robin among PENDING channels, starting after last-served channel; grant takes one cycle; ISSUE begins next cycle.
REQ-023 In ISSUE, mem_rd = dst_ready; each asserted cycle issues address start+k, k = 0..size, k increments only when mem_rd=1.
REQ-024 Address arithmetic modulo 2^ADDR_W; wrap past all-ones allowed, no error.
REQ-025 out_valid, out_ch, out_offset are mem_rd, channel, k delayed exactly one cycle; out_data = mem_rdata in that cycle.
REQ-026 After issuing k=size, FSM enters DRAIN for one cycle; ch_done pulses in the cycle the last out_valid is high; ch_busy clears the next cycle.
REQ-027 size=0 transfers exactly one beat.
REQ-028 ch_start on a busy channel is ignored and sets start_err; cleared only by reset.
REQ-029 Simultaneous ch_start on several idle channels: all go PENDING; served in round-robin order.
REQ-030 dst_ready low stalls issue indefinitely with no lost or duplicated beats.

Reset
REQ-031 HRESET asserted asynchronously forces: all channels IDLE, FSM IDLE, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_ch=0, out_offset=0, ch_busy=0, ch_done=0, start_err=0, round-robin pointer = NUM_CH-1 (ch0 first).
REQ-032 Reset mid-transfer discards the transfer; no ch_done is generated.

Configuration
REQ-033 Macro WRA_DMA_ABORT_EN: when defined, ch_abort exists; abort on PENDING returns channel to IDLE; abort on ACTIVE stops issue next cycle, lets any in-flight beat emerge, then returns IDLE without ch_done.
REQ-034 Without WRA_DMA_ABORT_EN, the ch_abort port is absent and transfers always complete.

Structure
REQ-035 Package wra_dma_pkg holds the engine-state enum, channel-state enum and default widths.
REQ-036 Sub-module wra_rr_arbiter (NUM_CH-wide round-robin grant) is instantiated once.

Verification
REQ-037 ch0 start, addr=0, size=195, dst_ready=1 -> 196 beats, addresses 0..195, out_offset 0..195, ch_done[0] with beat 195.
REQ-038 ch0 and ch1 start same cycle (ch1 addr=8,size=31) -> ch0 served fully first, then ch1 addresses 8..39, out_offset 0..31.
REQ-039 ch1 addr=0xFFFE, size=3 -> addresses FFFE, FFFF, 0000, 0001; no error.
REQ-040 dst_ready toggled 1/0 every cycle during size=7 -> exactly 8 beats, offsets contiguous 0..7.
REQ-041 ch0 re-started while active -> start_err=1, transfer unaffected; HRESET mid-transfer -> all outputs at reset values, no ch_done.
REQ-042 With WRA_DMA_ABORT_EN, abort ch0 at offset 10 of size 50 -> at most one further out_valid, ch_busy[0] clears, no ch_done[0].

Source files
------------

// File: rtl/wra_dma_pkg.sv
// Shared types and default widths for the wra_dma_reader DMA read engine.
// Optional feature macro: WRA_DMA_ABORT_EN (adds per-channel abort).
package wra_dma_pkg;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_DATA_W = 512;

    // Engine: grant in IDLE, stream reads in ISSUE, let the last beat land in DRAIN
    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_ISSUE = 2'd1,
        ENG_DRAIN = 2'd2
    } engState_t;

    // Per-channel request lifecycle
    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_PENDING = 2'd1,
        CH_ACTIVE  = 2'd2
    } chState_t;

endpackage

// File: rtl/wra_rr_arbiter.sv
// Combinational round-robin grant: first requester after the last-served channel.
module wra_rr_arbiter #(
    parameter int unsigned NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]          req,
    input  logic [$clog2(NUM_CH)-1:0]  lastCh,
    output logic [NUM_CH-1:0]          gnt,
    output logic [$clog2(NUM_CH)-1:0]  gntIdx,
    output logic                       gntValid
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    int unsigned idx;

    // Scan channels lastCh+1, lastCh+2, ... wrapping, take the first request
    always_comb begin
        gnt      = '0;
        gntIdx   = '0;
        gntValid = 1'b0;
        idx      = 0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            idx = (32'(lastCh) + 32'(i)) % NUM_CH;
            if (!gntValid && req[CH_W'(idx)]) begin
                gntValid           = 1'b1;
                gnt[CH_W'(idx)]    = 1'b1;
                gntIdx             = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wra_dma_reader.sv
// Multi-channel DMA reader: round-robin channel grant, one active transfer
// streaming beats from a synchronous memory with consumer back-pressure.
// Optional feature macro: WRA_DMA_ABORT_EN (adds ch_abort input).
module wra_dma_reader
    import wra_dma_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NUM_CH-1:0]          ch_start,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*CNT_W-1:0]    ch_size,
`ifdef WRA_DMA_ABORT_EN
    input  logic [NUM_CH-1:0]          ch_abort,
`endif
    input  logic                       dst_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [CNT_W-1:0]           out_offset,
    output logic [NUM_CH-1:0]          ch_busy,
    output logic [NUM_CH-1:0]          ch_done,
    output logic                       start_err
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    engState_t         engState;
    engState_t         engNext;
    chState_t          chState [NUM_CH];
    logic [ADDR_W-1:0] chAddrQ [NUM_CH];
    logic [CNT_W-1:0]  chSizeQ [NUM_CH];

    logic [CNT_W-1:0]  beatK;
    logic [CNT_W-1:0]  curSize;
    logic [CH_W-1:0]   curCh;
    logic [CH_W-1:0]   rrPtr;

    logic [NUM_CH-1:0] pendVec;
    logic [NUM_CH-1:0] reqVec;
    logic [NUM_CH-1:0] abortVec;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gntIdx;
    logic              gntValid;

    logic              grantFire;
    logic              issueFire;
    logic              lastIssue;
    logic              abortHit;

`ifdef WRA_DMA_ABORT_EN
    assign abortVec = ch_abort;
`else
    assign abortVec = '0;
`endif

    // Pending/busy decode of the channel state registers
    always_comb begin
        pendVec = '0;
        ch_busy = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pendVec[i] = (chState[i] == CH_PENDING);
            ch_busy[i] = (chState[i] != CH_IDLE);
        end
    end

    // A pending channel being aborted this cycle must not win the grant
    assign reqVec = pendVec & ~abortVec;

    wra_rr_arbiter #(.NUM_CH(NUM_CH)) uArb (
        .req      (reqVec),
        .lastCh   (rrPtr),
        .gnt      (gnt),
        .gntIdx   (gntIdx),
        .gntValid (gntValid)
    );

    // Engine state register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) engState <= ENG_IDLE;
        else        engState <= engNext;
    end

    // Engine next-state and per-cycle strobes
    always_comb begin
        engNext   = engState;
        grantFire = 1'b0;
        issueFire = 1'b0;
        lastIssue = 1'b0;
        abortHit  = 1'b0;
        case (engState)
            ENG_IDLE: begin
                if (gntValid) begin
                    grantFire = 1'b1;
                    engNext   = ENG_ISSUE;
                end
            end
            ENG_ISSUE: begin
                issueFire = dst_ready;
                lastIssue = dst_ready && (beatK == curSize);
                abortHit  = abortVec[curCh];
                if (lastIssue || abortHit) engNext = ENG_DRAIN;
            end
            ENG_DRAIN: engNext = ENG_IDLE;
            default:   engNext = ENG_IDLE;
        endcase
    end

    // Read strobe follows consumer readiness while issuing
    assign mem_rd   = issueFire;
    // Memory data arrives in the cycle the delayed beat is flagged valid
    assign out_data = out_valid ? mem_rdata : '0;

    // Transfer datapath: address/beat counters, delayed beat tags, done pulse
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mem_addr   <= '0;
            beatK      <= '0;
            curSize    <= '0;
            curCh      <= '0;
            rrPtr      <= CH_W'(NUM_CH - 1);
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_offset <= '0;
            ch_done    <= '0;
        end else begin
            out_valid <= issueFire;
            ch_done   <= (lastIssue && !abortHit) ? (NUM_CH'(1) << curCh) : '0;
            if (grantFire) begin
                mem_addr <= chAddrQ[gntIdx];
                beatK    <= '0;
                curSize  <= chSizeQ[gntIdx];
                curCh    <= gntIdx;
                rrPtr    <= gntIdx;
            end
            if (issueFire) begin
                out_ch     <= curCh;
                out_offset <= beatK;
                mem_addr   <= mem_addr + ADDR_W'(1);
                beatK      <= beatK + CNT_W'(1);
            end
        end
    end

    // Channel lifecycle, start sampling and sticky start error
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            start_err <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                chState[i] <= CH_IDLE;
                chAddrQ[i] <= '0;
                chSizeQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_start[i] && chState[i] != CH_IDLE) start_err <= 1'b1;
                if (grantFire && gnt[i]) begin
                    chState[i] <= CH_ACTIVE;
                end else if (engState == ENG_DRAIN && curCh == CH_W'(i)) begin
                    chState[i] <= CH_IDLE;
                end else if (abortVec[i] && chState[i] == CH_PENDING) begin
                    chState[i] <= CH_IDLE;
                end else if (ch_start[i] && chState[i] == CH_IDLE) begin
                    chState[i] <= CH_PENDING;
                    chAddrQ[i] <= ch_addr[i*ADDR_W +: ADDR_W];
                    chSizeQ[i] <= ch_size[i*CNT_W +: CNT_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_wra_dma_reader.sv
// Directed self-checking bench for wra_dma_reader (abort steps under WRA_DMA_ABORT_EN).
module tb_wra_dma_reader;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 512;

    logic                      HCLK = 1'b0;
    logic                      HRESET;
    logic [NUM_CH-1:0]         ch_start;
    logic [NUM_CH*ADDR_W-1:0]  ch_addr;
    logic [NUM_CH*CNT_W-1:0]   ch_size;
    logic [NUM_CH-1:0]         ch_abort;
    logic                      dst_ready;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_rd;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [0:0]                out_ch;
    logic [CNT_W-1:0]          out_offset;
    logic [NUM_CH-1:0]         ch_busy;
    logic [NUM_CH-1:0]         ch_done;
    logic                      start_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [0:0]        ch;
        logic [CNT_W-1:0]  off;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef struct {
        logic [NUM_CH-1:0] done;
        logic              v;
        logic [CNT_W-1:0]  off;
    } done_t;

    beat_t             beatQ[$];
    logic [ADDR_W-1:0] addrQ[$];
    done_t             doneQ[$];

    wra_dma_reader #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .ch_start   (ch_start),
        .ch_addr    (ch_addr),
        .ch_size    (ch_size),
`ifdef WRA_DMA_ABORT_EN
        .ch_abort   (ch_abort),
`endif
        .dst_ready  (dst_ready),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_offset (out_offset),
        .ch_busy    (ch_busy),
        .ch_done    (ch_done),
        .start_err  (start_err)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [DATA_W-1:0] dataOf(input logic [ADDR_W-1:0] a);
        return {32{a ^ 16'h5A5A}};
    endfunction

    // Synchronous memory: data for the address read appears next cycle
    always @(posedge HCLK) begin
        if (mem_rd === 1'b1) mem_rdata <= dataOf(mem_addr);
        else                 mem_rdata <= ~dataOf(mem_addr);
    end

    // Capture issued addresses, delivered beats and done pulses mid-cycle
    always @(negedge HCLK) begin
        if (mem_rd === 1'b1)    addrQ.push_back(mem_addr);
        if (out_valid === 1'b1) beatQ.push_back('{out_ch, out_offset, out_data});
        if (ch_done !== '0)     doneQ.push_back('{ch_done, out_valid, out_offset});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        beatQ.delete();
        addrQ.delete();
        doneQ.delete();
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic startCh(input int ch, input logic [15:0] a, input logic [15:0] s);
        ch_start[ch]          = 1'b1;
        ch_addr[ch*16 +: 16]  = a;
        ch_size[ch*16 +: 16]  = s;
        tick();
        ch_start = '0;
    endtask

    task automatic waitIdle(input int budget, input bit toggle, input string tag);
        int n;
        n = 0;
        tick();
        while (ch_busy !== '0 && n < budget) begin
            if (toggle) dst_ready = ~dst_ready;
            tick();
            n++;
        end
        check({tag, " idle-in-time"}, 64'(n < budget), 64'd1);
        tick();
    endtask

    task automatic checkReset(input string tag);
        check({tag, " mem_rd"},     64'(mem_rd),          64'd0);
        check({tag, " mem_addr"},   64'(mem_addr),        64'd0);
        check({tag, " out_valid"},  64'(out_valid),       64'd0);
        check({tag, " out_data0"},  64'(out_data === '0), 64'd1);
        check({tag, " out_ch"},     64'(out_ch),          64'd0);
        check({tag, " out_offset"}, 64'(out_offset),      64'd0);
        check({tag, " ch_busy"},    64'(ch_busy),         64'd0);
        check({tag, " ch_done"},    64'(ch_done),         64'd0);
        check({tag, " start_err"},  64'(start_err),       64'd0);
    endtask

    // Compare n logged beats/addresses from index first against a contiguous run
    task automatic checkRun(input string tag, input int first, input logic ch,
                            input logic [15:0] base, input int n);
        bit okMeta, okData, okAddr;
        logic [15:0] ea;
        okMeta = 1'b1;
        okData = 1'b1;
        okAddr = 1'b1;
        for (int j = 0; j < n; j++) begin
            ea = base + 16'(j);
            if (first + j >= beatQ.size()) begin
                okMeta = 1'b0;
                okData = 1'b0;
            end else begin
                if (beatQ[first+j].ch !== ch || beatQ[first+j].off !== 16'(j)) okMeta = 1'b0;
                if (beatQ[first+j].data !== dataOf(ea)) okData = 1'b0;
            end
            if (first + j >= addrQ.size() || addrQ[first+j] !== ea) okAddr = 1'b0;
        end
        check({tag, " ch/offset seq"}, 64'(okMeta), 64'd1);
        check({tag, " data seq"},      64'(okData), 64'd1);
        check({tag, " addr seq"},      64'(okAddr), 64'd1);
    endtask

    task automatic checkDone(input string tag, input int idx,
                             input logic [1:0] expDone, input logic [15:0] expOff);
        bit ok;
        ok = (idx < doneQ.size()) && doneQ[idx].done === expDone &&
             doneQ[idx].v === 1'b1 && doneQ[idx].off === expOff;
        check({tag, " done-with-last-beat"}, 64'(ok), 64'd1);
    endtask

    initial begin
        HRESET    = 1'b1;
        ch_start  = '0;
        ch_addr   = '0;
        ch_size   = '0;
        ch_abort  = '0;
        dst_ready = 1'b0;
        repeat (3) tick();
        checkReset("reset");
        HRESET = 1'b0;
        tick();

        // Long single transfer from address 0
        clearLogs();
        dst_ready = 1'b1;
        startCh(0, 16'h0000, 16'd195);
        check("t1 busy-after-start", 64'(ch_busy), 64'd1);
        waitIdle(400, 1'b0, "t1");
        check("t1 beat-count", 64'(beatQ.size()), 64'd196);
        check("t1 addr-count", 64'(addrQ.size()), 64'd196);
        checkRun("t1", 0, 1'b0, 16'h0000, 196);
        check("t1 done-count", 64'(doneQ.size()), 64'd1);
        checkDone("t1", 0, 2'b01, 16'd195);
        check("t1 start_err", 64'(start_err), 64'd0);

        // Simultaneous starts after a fresh reset: ch0 then ch1
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        tick();
        clearLogs();
        ch_start = 2'b11;
        ch_addr  = {16'd8, 16'd100};
        ch_size  = {16'd31, 16'd3};
        tick();
        ch_start = '0;
        check("t2 both-busy", 64'(ch_busy), 64'd3);
        waitIdle(200, 1'b0, "t2");
        check("t2 beat-count", 64'(beatQ.size()), 64'd36);
        checkRun("t2 ch0", 0, 1'b0, 16'd100, 4);
        checkRun("t2 ch1", 4, 1'b1, 16'd8, 32);
        check("t2 done-count", 64'(doneQ.size()), 64'd2);
        checkDone("t2 ch0", 0, 2'b01, 16'd3);
        checkDone("t2 ch1", 1, 2'b10, 16'd31);

        // Address wrap past all-ones
        clearLogs();
        startCh(1, 16'hFFFE, 16'd3);
        waitIdle(50, 1'b0, "t3");
        check("t3 beat-count", 64'(beatQ.size()), 64'd4);
        checkRun("t3", 0, 1'b1, 16'hFFFE, 4);
        check("t3 third-addr", 64'(addrQ.size() > 2 ? addrQ[2] : 16'hDEAD), 64'h0000);
        checkDone("t3", 0, 2'b10, 16'd3);
        check("t3 start_err", 64'(start_err), 64'd0);

        // Back-pressure toggling every cycle
        clearLogs();
        startCh(0, 16'h0040, 16'd7);
        waitIdle(100, 1'b1, "t4");
        dst_ready = 1'b1;
        check("t4 beat-count", 64'(beatQ.size()), 64'd8);
        check("t4 addr-count", 64'(addrQ.size()), 64'd8);
        checkRun("t4", 0, 1'b0, 16'h0040, 8);
        checkDone("t4", 0, 2'b01, 16'd7);

        // Restart of an active channel is rejected
        clearLogs();
        startCh(0, 16'h0200, 16'd20);
        repeat (5) tick();
        startCh(0, 16'h0999, 16'd2);
        check("t5 start_err-set", 64'(start_err), 64'd1);
        waitIdle(100, 1'b0, "t5");
        check("t5 beat-count", 64'(beatQ.size()), 64'd21);
        checkRun("t5", 0, 1'b0, 16'h0200, 21);
        check("t5 done-count", 64'(doneQ.size()), 64'd1);
        check("t5 start_err-sticky", 64'(start_err), 64'd1);

        // Reset mid-transfer
        clearLogs();
        startCh(0, 16'h0300, 16'd30);
        repeat (8) tick();
        HRESET = 1'b1;
        #1;
        checkReset("t5 midreset");
        tick();
        HRESET = 1'b0;
        repeat (5) tick();
        check("t5 no-done-after-reset", 64'(doneQ.size()), 64'd0);
        check("t5 idle-after-reset", 64'(ch_busy), 64'd0);

`ifdef WRA_DMA_ABORT_EN
        // Abort an active transfer around offset 10
        begin
            int n;
            int n0;
            clearLogs();
            startCh(0, 16'h0000, 16'd50);
            n = 0;
            while (!(out_valid === 1'b1 && out_offset === 16'd10) && n < 100) begin
                tick();
                n++;
            end
            check("t6 reached-offset10", 64'(n < 100), 64'd1);
            ch_abort = 2'b01;
            @(negedge HCLK);
            n0 = beatQ.size();
            tick();
            ch_abort = '0;
            waitIdle(50, 1'b0, "t6");
            check("t6 at-most-one-more-beat", 64'((beatQ.size() - n0) <= 1), 64'd1);
            check("t6 busy-cleared", 64'(ch_busy), 64'd0);
            check("t6 no-done", 64'(doneQ.size()), 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
